keypad_matrix_scanner: RTL and testbench
========================================

# keypad_matrix_scanner

Parametrised matrix-keypad scanner for the elevator's interior request panel, with a second request source for the exterior call button. It drives one-hot column strobes, samples the row lines, debounces over whole scan frames, and queues press events from both sources in a small FIFO with a valid/ready output. Unlike the previous scanner, scanning never halts on a press, multi-key frames are rejected, and events are queued rather than overwritten.

## Interface
- `ROWS`, default 4: row sense lines.
- `COLS`, default 4: column drive lines.
- `SCAN_DIV`, default 32768: clock cycles each column is driven.
- `DEBOUNCE`, default 4: identical consecutive frames required to accept a press or release (≥1).
- `FIFO_DEPTH`, default 4: event queue entries (power of 2, ≥2).
- `CODE_W`, derived as clog2(ROWS*COLS): key code width.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `col_drive`, out, COLS: one-hot column strobe.
- `row_sense`, in, ROWS: row returns (asynchronous; pass through a 2-flop synchroniser).
- `call_req`, in, 1: exterior call button (synchronous, level).
- `call_code`, in, CODE_W: floor code queued on a `call_req` rising edge.
- `key_valid`, out, 1: FIFO head valid.
- `key_code`, out, CODE_W: head code.
- `key_src`, out, 1: head source; 0 = keypad, 1 = call.
- `key_ready`, in, 1: consumer accepts the head.
- `key_held`, out, 1: a debounced keypad key is currently held.
- `overflow`, out, 1: sticky; an event was dropped.

## Operation
- **Scan.** `div_cnt` counts 0..SCAN_DIV-1. At the terminal count, `col_idx` advances and wraps from COLS-1 to 0, and `col_drive` = 1<<col_idx.
- **Sampling.** The synchronised `row_sense` is sampled on the terminal-count cycle of each column.
- **Frame.** One frame is COLS*SCAN_DIV cycles and ends when column COLS-1 reaches its terminal count.
- **Frame result.**
  - Exactly one sampled bit set in the whole frame: KEY, with code = col*ROWS + row.
  - No bits set: NONE.
  - Two or more bits set: treated as NONE (ghost rejection).
- **Debounce.** At frame end, if the result equals the previous result, `stable_cnt` increments, saturating at DEBOUNCE. Otherwise `stable_cnt` is set to 1.
- **FSM (updates at frame end only).**
  - IDLE: KEY with stable_cnt = DEBOUNCE → HELD and emit a press event.
  - HELD: NONE with stable_cnt = DEBOUNCE → IDLE. A different KEY stable for DEBOUNCE frames → HELD and emit that new code.
  - `key_held` = (state == HELD).
- **Call path.** A rising edge of `call_req` (registered previous value) creates the event {src=1, call_code}.
- **Arbitration.** If a call event and a keypad event occur in the same cycle, the call is pushed first. The keypad event waits in a 1-entry pending register and is pushed the next cycle. A new keypad event cannot arrive before then, since events are frame-spaced.
- **FIFO.** First-word fall-through. Pop occurs when key_valid && key_ready.
  - Push when full with no pop: the event is dropped and `overflow` sets until reset.
  - Push and pop in the same cycle when full: accepted, no drop.
  - Push when empty: `key_valid` rises the next cycle.

## Timing
- **Reset values.** col_drive = 1 (column 0), div_cnt = 0, col_idx = 0, state IDLE, stable_cnt = 0, previous result NONE, FIFO empty, key_valid = 0, key_code = 0, key_src = 0, key_held = 0, overflow = 0, pending empty, call_req history = 0.
- **Reset mid-operation.** Asynchronous reset discards queued, pending and debounce state immediately.
- **Synchroniser latency.** `row_sense` edges need ≥2 cycles before a sample point to be captured.
- **Press latency.** A key stable from frame k is accepted at the end of frame k+DEBOUNCE-1. Its event is pushed that cycle and is visible at `key_valid` one cycle later. `key_held` rises in the same cycle as the push.
- **Call latency.** `call_req` rising at cycle t gives `key_valid` at t+2 if the FIFO was empty (edge detect, then push).
- **Outputs.** `key_code` and `key_src` are stable while key_valid=1 && key_ready=0.

## Test plan
Bench parameters: ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4. One frame is 16 cycles.

1. **Idle scan.** Release reset, no keys → col_drive sequence 0001,0010,0100,1000, 4 cycles each, repeating; key_valid stays 0.
2. **Single press.** Row 1 asserted whenever col 2 is driven, held for 3 frames → exactly one event {src=0, code=9}, key_held=1. Releasing for 2 frames → key_held=0 and no further event.
3. **Bounce and ghost.**
   - Press lasting 1 frame only → no event.
   - Rows 0 and 1 both asserted in col 0 for 4 frames → no event.
4. **Call with simultaneous press.** call_req rises with call_code=5 in the same cycle a keypad code 9 is accepted → FIFO holds {1,5} then {0,9}, pushed on consecutive cycles.
5. **Overflow.** key_ready=0, five call edges → 4 events queued and overflow=1. Popping with key_ready=1 returns them in order. overflow stays 1 until rst_n pulses low.
6. **Reset mid-frame.** rst_n low during column 2 with 2 queued events → col_drive=0001, key_valid=0, key_held=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/keypad_matrix_scanner_if.sv
// rtl/keypad_matrix_scanner_if.sv - key event stream between the scanner queue and its consumer
interface keypad_matrix_scanner_if #(
    parameter int CODE_W = 4
);
    logic              key_valid;
    logic              key_ready;
    logic [CODE_W-1:0] key_code;
    logic              key_src;

    modport master (
        output key_valid,
        output key_code,
        output key_src,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_src,
        output key_ready
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - matrix keypad scanner with frame debounce, call-button merge and event FIFO
module keypad_matrix_scanner #(
    parameter int  ROWS       = 4,
    parameter int  COLS       = 4,
    parameter int  SCAN_DIV   = 32768,
    parameter int  DEBOUNCE   = 4,
    parameter int  FIFO_DEPTH = 4,
    localparam int CODE_W     = $clog2(ROWS * COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [COLS-1:0]      col_drive,
    input  logic [ROWS-1:0]      row_sense,
    input  logic                 call_req,
    input  logic [CODE_W-1:0]    call_code,
    keypad_matrix_scanner_if.master key_bus,
    output logic                 key_held,
    output logic                 overflow
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int STB_W = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = CODE_W + 1;

    typedef enum logic {S_IDLE, S_HELD} state_t;

    logic [DIV_W-1:0]  div_cnt;
    logic [COL_W-1:0]  col_idx;
    logic [ROWS-1:0]   row_s1, row_s2;
    logic              tc, frame_end;

    logic [1:0]        acc_hits, row_hits, tot_hits;
    logic [2:0]        hit_sum;
    logic [CODE_W-1:0] acc_code, samp_code, frame_code, prev_code, held_code;
    int                row_pos;
    logic              frame_key, prev_key, same, settled;
    logic [STB_W-1:0]  stable_cnt, stable_next;
    state_t            state;
    logic              kp_evt;

    logic              call_prev, call_evt;
    logic [CODE_W-1:0] call_code_q;
    logic              pend_v;
    logic [CODE_W-1:0] pend_code;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              push, pop, full, accept;
    logic [ENT_W-1:0]  push_data;

    assign tc        = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = tc && (col_idx == COL_W'(COLS - 1));
    assign col_drive = COLS'(1) << col_idx;
    assign key_held  = (state == S_HELD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            col_idx <= '0;
            row_s1  <= '0;
            row_s2  <= '0;
        end else begin
            row_s1 <= row_sense;
            row_s2 <= row_s1;
            if (tc) begin
                div_cnt <= '0;
                col_idx <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Hit count saturates at 2: anything beyond one hit is a ghost/multi-key frame.
    always_comb begin
        row_hits = 2'd0;
        row_pos  = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_s2[r]) begin
                row_pos = r;
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
            end
        end
        samp_code  = CODE_W'(int'(col_idx) * ROWS + row_pos);
        hit_sum    = {1'b0, acc_hits} + {1'b0, row_hits};
        tot_hits   = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_key  = (tot_hits == 2'd1);
        frame_code = (acc_hits == 2'd1) ? acc_code : samp_code;
        same       = (frame_key == prev_key) && (!frame_key || frame_code == prev_code);
        if (!same)
            stable_next = STB_W'(1);
        else if (stable_cnt == STB_W'(DEBOUNCE))
            stable_next = stable_cnt;
        else
            stable_next = stable_cnt + STB_W'(1);
        settled = (stable_next == STB_W'(DEBOUNCE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hits   <= 2'd0;
            acc_code   <= '0;
            prev_key   <= 1'b0;
            prev_code  <= '0;
            stable_cnt <= '0;
            state      <= S_IDLE;
            held_code  <= '0;
            kp_evt     <= 1'b0;
        end else begin
            kp_evt <= 1'b0;
            if (frame_end) begin
                acc_hits   <= 2'd0;
                acc_code   <= '0;
                prev_key   <= frame_key;
                prev_code  <= frame_key ? frame_code : '0;
                stable_cnt <= stable_next;
                case (state)
                    S_IDLE: begin
                        if (frame_key && settled) begin
                            state     <= S_HELD;
                            held_code <= frame_code;
                            kp_evt    <= 1'b1;
                        end
                    end
                    S_HELD: begin
                        if (settled) begin
                            if (!frame_key) begin
                                state <= S_IDLE;
                            end else if (frame_code != held_code) begin
                                held_code <= frame_code;
                                kp_evt    <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (tc) begin
                acc_hits <= tot_hits;
                if (acc_hits == 2'd0) acc_code <= samp_code;
            end
        end
    end

    // Call wins a same-cycle collision; the keypad event is parked in pend for one cycle.
    always_comb begin
        push      = 1'b1;
        push_data = '0;
        if (call_evt)
            push_data = {1'b1, call_code_q};
        else if (pend_v)
            push_data = {1'b0, pend_code};
        else if (kp_evt)
            push_data = {1'b0, held_code};
        else
            push = 1'b0;
        pop    = (count != '0) && key_bus.key_ready;
        full   = (count == (PTR_W + 1)'(FIFO_DEPTH));
        accept = push && (!full || pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            call_prev   <= 1'b0;
            call_evt    <= 1'b0;
            call_code_q <= '0;
            pend_v      <= 1'b0;
            pend_code   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            call_prev   <= call_req;
            call_evt    <= call_req && !call_prev;
            call_code_q <= call_code;

            if (kp_evt && (call_evt || pend_v)) begin
                pend_v    <= 1'b1;
                pend_code <= held_code;
            end else if (pend_v && !call_evt) begin
                pend_v <= 1'b0;
            end

            if (accept) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (push && !accept) overflow <= 1'b1;
        end
    end

    assign key_bus.key_valid = (count != '0);
    assign key_bus.key_src   = mem[rd_ptr][ENT_W-1];
    assign key_bus.key_code  = mem[rd_ptr][CODE_W-1:0];
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - directed self-checking bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_drive;
    logic [3:0] row_sense;
    logic       call_req = 1'b0;
    logic [3:0] call_code = 4'h0;
    logic       key_held;
    logic       overflow;

    logic       press_en = 1'b0;
    logic [1:0] press_col = 2'd0;
    logic [3:0] press_rows = 4'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    keypad_matrix_scanner_if #(.CODE_W(4)) kif();

    // Keypad model: the pressed rows return only while their column is strobed.
    assign row_sense = (press_en && col_drive[press_col]) ? press_rows : 4'b0;

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col_drive(col_drive),
        .row_sense(row_sense),
        .call_req(call_req),
        .call_code(call_code),
        .key_bus(kif),
        .key_held(key_held),
        .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic align();
        while (cyc % 16 != 0) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        kif.key_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col_drive", 32'(col_drive), 32'h1);
        check("rst_key_valid", 32'(kif.key_valid), 32'h0);
        check("rst_key_code", 32'(kif.key_code), 32'h0);
        check("rst_key_src", 32'(kif.key_src), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        cyc = 0;

        // 1. idle scan
        for (int i = 0; i < 32; i++) begin
            check("scan_col_drive", 32'(col_drive), 32'(1 << ((i / 4) % 4)));
            check("scan_key_valid", 32'(kif.key_valid), 32'h0);
            tick();
        end

        // 2. single press: col 2, row 1 -> code 9, held 3 frames
        align();
        press_col = 2'd2; press_rows = 4'b0010; press_en = 1'b1;
        ticks(16);
        check("press_held_early", 32'(key_held), 32'h0);
        check("press_valid_early", 32'(kif.key_valid), 32'h0);
        ticks(16);
        check("press_held", 32'(key_held), 32'h1);
        check("press_valid_push_cycle", 32'(kif.key_valid), 32'h0);
        tick();
        check("press_valid", 32'(kif.key_valid), 32'h1);
        check("press_code", 32'(kif.key_code), 32'h9);
        check("press_src", 32'(kif.key_src), 32'h0);
        kif.key_ready = 1'b1;
        tick();
        kif.key_ready = 1'b0;
        check("press_popped", 32'(kif.key_valid), 32'h0);
        align();
        press_en = 1'b0;
        ticks(16);
        check("release_held_still", 32'(key_held), 32'h1);
        ticks(16);
        check("release_held", 32'(key_held), 32'h0);
        check("release_no_event", 32'(kif.key_valid), 32'h0);

        // 3a. one-frame bounce: col 1 row 3
        align();
        press_col = 2'd1; press_rows = 4'b1000; press_en = 1'b1;
        ticks(16);
        press_en = 1'b0;
        ticks(32);
        check("bounce_valid", 32'(kif.key_valid), 32'h0);
        check("bounce_held", 32'(key_held), 32'h0);

        // 3b. ghost: rows 0 and 1 in col 0 for 4 frames
        press_col = 2'd0; press_rows = 4'b0011; press_en = 1'b1;
        ticks(64);
        press_en = 1'b0;
        check("ghost_valid", 32'(kif.key_valid), 32'h0);
        check("ghost_held", 32'(key_held), 32'h0);
        ticks(32);

        // 4. call rising in the same cycle code 9 is accepted
        align();
        press_col = 2'd2; press_rows = 4'b0010; press_en = 1'b1;
        ticks(31);
        call_code = 4'h5; call_req = 1'b1;
        tick();
        press_en = 1'b0;
        check("coll_held", 32'(key_held), 32'h1);
        check("coll_valid_push_cycle", 32'(kif.key_valid), 32'h0);
        tick();
        call_req = 1'b0;
        check("coll_first_valid", 32'(kif.key_valid), 32'h1);
        check("coll_first_code", 32'(kif.key_code), 32'h5);
        check("coll_first_src", 32'(kif.key_src), 32'h1);
        tick();
        check("coll_first_stable", 32'(kif.key_code), 32'h5);
        kif.key_ready = 1'b1;
        tick();
        check("coll_second_valid", 32'(kif.key_valid), 32'h1);
        check("coll_second_code", 32'(kif.key_code), 32'h9);
        check("coll_second_src", 32'(kif.key_src), 32'h0);
        tick();
        kif.key_ready = 1'b0;
        check("coll_drained", 32'(kif.key_valid), 32'h0);
        align();
        ticks(16);
        check("coll_released", 32'(key_held), 32'h0);

        // 5. overflow: five call edges into a 4-deep queue
        for (int i = 1; i <= 5; i++) begin
            call_code = 4'(i); call_req = 1'b1;
            tick();
            call_req = 1'b0;
            tick();
            if (i == 4) check("ovf_not_yet", 32'(overflow), 32'h0);
        end
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_valid", 32'(kif.key_valid), 32'h1);
        kif.key_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order_code", 32'(kif.key_code), 32'(i));
            check("ovf_order_src", 32'(kif.key_src), 32'h1);
            tick();
        end
        kif.key_ready = 1'b0;
        check("ovf_empty", 32'(kif.key_valid), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // 6. async reset during column 2 with two queued events and a held key
        align();
        press_col = 2'd2; press_rows = 4'b0010; press_en = 1'b1;
        ticks(33);
        call_code = 4'h3; call_req = 1'b1;
        tick();
        call_req = 1'b0;
        tick();
        while (cyc % 16 != 9) tick();
        check("pre_rst_col", 32'(col_drive), 32'h4);
        check("pre_rst_valid", 32'(kif.key_valid), 32'h1);
        check("pre_rst_held", 32'(key_held), 32'h1);
        check("pre_rst_overflow", 32'(overflow), 32'h1);
        #2 rst_n = 1'b0;
        press_en = 1'b0;
        #1;
        check("async_rst_col", 32'(col_drive), 32'h1);
        check("async_rst_valid", 32'(kif.key_valid), 32'h0);
        check("async_rst_held", 32'(key_held), 32'h0);
        check("async_rst_overflow", 32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        // call latency: rise at t, valid at t+2
        call_code = 4'hA; call_req = 1'b1;
        tick();
        check("call_lat_t1", 32'(kif.key_valid), 32'h0);
        tick();
        call_req = 1'b0;
        check("call_lat_t2", 32'(kif.key_valid), 32'h1);
        check("call_lat_code", 32'(kif.key_code), 32'hA);
        check("call_lat_src", 32'(kif.key_src), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
